// File: rtl/fetch_pc_unit.sv
// Program-counter generator and instruction-fetch request controller for the IF stage.
// Redirects arriving while a memory request is outstanding are buffered and the wrong-path fetch is killed.
module fetch_pc_unit #(
  parameter int                  XLEN          = 32,
  parameter logic [XLEN-1:0]     RESET_VECTOR  = 32'h0000_0000,
  parameter int                  STEP          = 4,
  parameter int                  CAUSE_W       = 2,
  parameter logic [CAUSE_W-1:0]  NOT_EXCEPTION = 2'b00,
  parameter bit                  VECTORED      = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jump,
  input  logic [XLEN-1:0]    c,
  input  logic [CAUSE_W-1:0] exception_cause,
  input  logic [XLEN-1:0]    exception_handling_addr,
  input  logic               imem_ready,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  output logic               fetch_valid,
  output logic [XLEN-1:0]    fetch_pc,
  output logic [XLEN-1:0]    pc4
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;

  logic            redirect;
  logic [XLEN-1:0] exc_target;
  logic [XLEN-1:0] target;
  logic            handshake;

  // Cause is zero-extended before scaling into the vector table.
  generate
    if (VECTORED) begin : g_vectored
      assign exc_target = exception_handling_addr + (XLEN'(exception_cause) << 2);
    end else begin : g_direct
      assign exc_target = exception_handling_addr;
    end
  endgenerate

  assign redirect  = jump | (exception_cause != NOT_EXCEPTION);
  assign target    = jump ? c : exc_target;
  assign pc4       = pc_q + XLEN'(STEP);
  assign imem_addr = pc_q;
  assign fetch_pc  = pc_q;
  assign handshake = imem_req & imem_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    imem_req     = 1'b0;
    fetch_valid  = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req    = !stall;
        fetch_valid = handshake & !redirect & !pend_valid_q;
        if (redirect) begin
          pc_d = target;
        end else if (pend_valid_q) begin
          pc_d         = pend_addr_q;
          pend_valid_d = 1'b0;
        end else if (handshake) begin
          pc_d = pc4;
        end
        if (imem_req && !imem_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Address must stay stable until memory completes, so redirects are parked.
        imem_req = 1'b1;
        if (imem_ready) begin
          state_d = ST_FETCH;
          if (redirect || pend_valid_q) begin
            pc_d         = redirect ? target : pend_addr_q;
            pend_valid_d = 1'b0;
          end else if (!stall) begin
            fetch_valid = 1'b1;
            pc_d        = pc4;
          end
        end else if (redirect) begin
          pend_addr_d  = target;
          pend_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Parametrised program-counter generator and instruction-fetch request controller for the IF stage. It owns the PC register and drives a valid/ready request to instruction memory. It resolves next-PC priority between jump, exception and sequential fetch, with optional vectored exception targets. Redirects that arrive while a memory request is outstanding are buffered, and the wrong-path fetch is killed.

Parameters:
XLEN, 32, address/PC width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
STEP, 4, sequential PC increment in bytes
CAUSE_W, 2, exception cause width
NOT_EXCEPTION, 2'b00, cause encoding meaning "no exception"
VECTORED, 0, 0: exception target = base; 1: exception target = base + (cause << 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  decode cannot accept a new instruction this cycle
jump  in  1  taken jump/branch redirect request
c  in  XLEN  jump target
exception_cause  in  CAUSE_W  exception cause; NOT_EXCEPTION = none
exception_handling_addr  in  XLEN  exception handler base address
imem_ready  in  1  instruction memory accepts/completes the current request
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (the current PC)
fetch_valid  out  1  fetched instruction is valid and correct-path this cycle
fetch_pc  out  XLEN  PC of the instruction qualified by fetch_valid
pc4  out  XLEN  current PC + STEP

Behaviour:
- Reset: one clock, synchronous, active-high. On reset: pc=RESET_VECTOR, state=BOOT, pend_valid=0, pend_addr=0, imem_req=0, fetch_valid=0. A reset in any state, including WAIT, drops an outstanding request immediately.
- Redirect and target:
  - redirect = jump | (exception_cause != NOT_EXCEPTION).
  - target = jump ? c : exc_target. Jump has priority over exception.
  - exc_target = VECTORED ? exception_handling_addr + (cause << 2) : exception_handling_addr.
- Arithmetic: all sums are modulo 2^XLEN. pc = 2^XLEN - STEP gives pc4 = 0. Cause is zero-extended before the shift.
- Outputs: imem_addr = pc, fetch_pc = pc, pc4 = pc + STEP (combinational from the PC register).
- States:
  - BOOT: imem_req=0. Next state FETCH unconditionally.
  - FETCH:
    - imem_req = !stall.
    - Handshake completes when imem_req & imem_ready; then fetch_valid = !redirect & !pend_valid.
    - pc update, in priority order: redirect -> target; else pend_valid -> pend_addr (clear pend_valid); else handshake completed -> pc4; else hold.
    - A redirect while stall=1 still updates pc. Redirect has priority over stall.
    - imem_req & !imem_ready -> WAIT.
  - WAIT:
    - imem_req=1 and imem_addr held stable until imem_ready, regardless of stall.
    - A redirect here latches pend_addr=target, pend_valid=1. A newer redirect overwrites the pending one.
    - On imem_ready, go to FETCH:
      - Any redirect in this cycle or pend_valid=1: fetch_valid=0 and pc = redirect ? target : pend_addr; clear pend_valid.
      - Else if stall=1: fetch_valid=0 and pc held, so the instruction is refetched.
      - Else: fetch_valid=1 and pc = pc4.
- fetch_valid is only ever high in the cycle the handshake completes.
- Latency: a redirect in FETCH issues its target fetch the next cycle.
- Back-to-back: with imem_ready tied high and no stall, one fetch per cycle at pc, pc+STEP, and so on.

Test Plan:
- Reset release, imem_ready=1, no stall -> BOOT cycle with imem_req=0; then imem_addr 0x0, 0x4, 0x8 on consecutive cycles, each with fetch_valid=1.
- pc=0x100, jump=1, c=0x200, and exception_cause=2'b01 in the same cycle -> next imem_addr=0x200 (jump wins) and fetch_valid=0 that cycle.
- VECTORED=1, base=0x8000_0000, cause=2'b11 -> next pc=0x8000_000C. With VECTORED=0 -> next pc=0x8000_0000.
- imem_ready low for 3 cycles at pc=0x40 with a jump to 0x300 in the 2nd wait cycle -> imem_addr stays 0x40 throughout; on ready fetch_valid=0, next imem_addr=0x300.
- stall=1 in FETCH at pc=0x80 -> imem_req=0 and pc holds. stall=1 at WAIT completion -> fetch_valid=0 and 0x80 is refetched.
- pc=0xFFFF_FFFC, sequential fetch -> pc4=0x0 and the next imem_addr=0x0. Reset asserted mid-WAIT -> imem_req=0 the next cycle and pc=RESET_VECTOR.
